// File: rtl/decode_hazard.sv
// -----------------------------------------------------------------------------
// decode_hazard
//
// Instruction-decode stage of a 5-stage 16-bit pipeline. It holds the 8x16
// register file, decodes the IF/ID instruction into the ID/EX pipeline
// register and detects load-use hazards against the instruction in ID/EX.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   instr_IFID          : instruction in IF/ID
//   PC2_IFID            : PC+2 of that instruction
//   halt_IFID           : halt flag from fetch
//   takeBranch_EXMEM    : branch taken in EX/MEM, flushes ID/EX to a NOP
//   freeze              : 1 = pipeline advances, 0 = all state holds
//   wrEn_WB/wrReg_WB/wrData_WB : register-file write port from write-back
//   stallCtrl           : load-use hazard (combinational)
//   startStall          : first cycle of a stall
//   *_IDEX              : ID/EX pipeline register outputs
//   err                 : IF/ID holds an unknown opcode (combinational)
//
// Configuration
//   RF_BYPASS_EN        : when defined, a read port whose index matches an
//                         active write-back returns wrData_WB (write-before-
//                         read). Otherwise the pre-write value is returned.
// -----------------------------------------------------------------------------
module decode_hazard (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_IFID,
    input  logic [15:0] PC2_IFID,
    input  logic        halt_IFID,
    input  logic        takeBranch_EXMEM,
    input  logic        freeze,
    input  logic        wrEn_WB,
    input  logic [2:0]  wrReg_WB,
    input  logic [15:0] wrData_WB,
    output logic        stallCtrl,
    output logic        startStall,
    output logic [15:0] rsData_IDEX,
    output logic [15:0] rtData_IDEX,
    output logic [15:0] imm_IDEX,
    output logic [15:0] PC2_IDEX,
    output logic [15:0] instr_IDEX,
    output logic [2:0]  wrReg_IDEX,
    output logic        regWrite_IDEX,
    output logic        memRead_IDEX,
    output logic        memWrite_IDEX,
    output logic        halt_IDEX,
    output logic        err
);

    typedef enum logic [4:0] {
        OP_HALT = 5'b00000,
        OP_NOP  = 5'b00001,
        OP_ADDI = 5'b01000,
        OP_ST   = 5'b10000,
        OP_LD   = 5'b10001,
        OP_RALU = 5'b11011
    } opcode_e;

    // Canonical NOP encoding placed in ID/EX for bubbles, flushes and resets.
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef struct packed {
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [15:0] imm;
        logic [15:0] pc2;
        logic [15:0] instr;
        logic [2:0]  wr_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        halt;
    } idex_t;

    function automatic idex_t idex_bubble();
        idex_t b;
        b       = '0;
        b.instr = NOP_INSTR;
        return b;
    endfunction

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    logic [15:0] r_rf [8];

    // NOTE: the register file must come up cleared, so it is reset like any
    // other flop; this keeps it out of RAM macros, which is fine at 8 entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else if (freeze && wrEn_WB) begin
            r_rf[wrReg_WB] <= wrData_WB;
        end
    end

    logic [2:0]  w_rs_idx;
    logic [2:0]  w_rt_idx;
    logic [15:0] w_rs_val;
    logic [15:0] w_rt_val;

    assign w_rs_idx = instr_IFID[10:8];
    assign w_rt_idx = instr_IFID[7:5];

`ifdef RF_BYPASS_EN
    // Write-before-read: a same-cycle write-back is visible to decode.
    assign w_rs_val = (wrEn_WB && (wrReg_WB == w_rs_idx)) ? wrData_WB : r_rf[w_rs_idx];
    assign w_rt_val = (wrEn_WB && (wrReg_WB == w_rt_idx)) ? wrData_WB : r_rf[w_rt_idx];
`else
    assign w_rs_val = r_rf[w_rs_idx];
    assign w_rt_val = r_rf[w_rt_idx];
`endif

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    logic [4:0]  w_opcode;
    logic [15:0] w_imm_sext;
    logic        w_uses_rs;
    logic        w_uses_rt;
    logic        w_legal;
    logic        w_is_halt;
    idex_t       w_dec;

    assign w_opcode   = instr_IFID[15:11];
    assign w_imm_sext = {{11{instr_IFID[4]}}, instr_IFID[4:0]};

    // NOTE: every output of this block gets a default before the case, so
    // no path through it leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_dec     = idex_bubble();
        w_uses_rs = 1'b0;
        w_uses_rt = 1'b0;
        w_legal   = 1'b1;
        w_is_halt = 1'b0;
        case (opcode_e'(w_opcode))
            OP_RALU: begin
                w_uses_rs       = 1'b1;
                w_uses_rt       = 1'b1;
                w_dec.instr     = instr_IFID;
                w_dec.pc2       = PC2_IFID;
                w_dec.rs_data   = w_rs_val;
                w_dec.rt_data   = w_rt_val;
                w_dec.wr_reg    = instr_IFID[4:2];
                w_dec.reg_write = 1'b1;
            end
            OP_ADDI: begin
                w_uses_rs       = 1'b1;
                w_dec.instr     = instr_IFID;
                w_dec.pc2       = PC2_IFID;
                w_dec.rs_data   = w_rs_val;
                w_dec.imm       = w_imm_sext;
                w_dec.wr_reg    = instr_IFID[7:5];
                w_dec.reg_write = 1'b1;
            end
            OP_LD: begin
                w_uses_rs       = 1'b1;
                w_dec.instr     = instr_IFID;
                w_dec.pc2       = PC2_IFID;
                w_dec.rs_data   = w_rs_val;
                w_dec.imm       = w_imm_sext;
                w_dec.wr_reg    = instr_IFID[7:5];
                w_dec.reg_write = 1'b1;
                w_dec.mem_read  = 1'b1;
            end
            OP_ST: begin
                w_uses_rs       = 1'b1;
                w_uses_rt       = 1'b1;
                w_dec.instr     = instr_IFID;
                w_dec.pc2       = PC2_IFID;
                w_dec.rs_data   = w_rs_val;
                w_dec.rt_data   = w_rt_val;
                w_dec.imm       = w_imm_sext;
                w_dec.mem_write = 1'b1;
            end
            OP_NOP: begin
                w_dec.instr = instr_IFID;
                w_dec.pc2   = PC2_IFID;
            end
            OP_HALT: begin
                w_is_halt   = 1'b1;
                w_dec.instr = instr_IFID;
                w_dec.pc2   = PC2_IFID;
            end
            default: begin
                // Unknown opcode: ID/EX receives the canonical bubble.
                w_legal = 1'b0;
            end
        endcase
        // Halt travels with the instruction; flush/stall suppress it below.
        w_dec.halt = halt_IFID | w_is_halt;
    end

    assign err = ~w_legal;

    // -------------------------------------------------------------------------
    // Load-use hazard
    // -------------------------------------------------------------------------
    logic  w_load_use;
    logic  r_stall_q;
    idex_t r_idex;
    idex_t w_next;

    // Only sources the IF/ID instruction really reads can create a hazard.
    assign w_load_use = r_idex.mem_read &&
                        ((w_uses_rs && (r_idex.wr_reg == w_rs_idx)) ||
                         (w_uses_rt && (r_idex.wr_reg == w_rt_idx)));

    // A flush discards the dependent instruction anyway, so it wins.
    assign stallCtrl  = w_load_use & ~takeBranch_EXMEM;
    assign startStall = stallCtrl & ~r_stall_q;

    always_comb begin
        w_next = w_dec;
        if (takeBranch_EXMEM || stallCtrl) begin
            w_next = idex_bubble();
        end
    end

    // -------------------------------------------------------------------------
    // ID/EX register and stall history
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idex    <= idex_bubble();
            r_stall_q <= 1'b0;
        end else if (freeze) begin
            r_idex    <= w_next;
            r_stall_q <= stallCtrl;
        end
    end

    assign rsData_IDEX   = r_idex.rs_data;
    assign rtData_IDEX   = r_idex.rt_data;
    assign imm_IDEX      = r_idex.imm;
    assign PC2_IDEX      = r_idex.pc2;
    assign instr_IDEX    = r_idex.instr;
    assign wrReg_IDEX    = r_idex.wr_reg;
    assign regWrite_IDEX = r_idex.reg_write;
    assign memRead_IDEX  = r_idex.mem_read;
    assign memWrite_IDEX = r_idex.mem_write;
    assign halt_IDEX     = r_idex.halt;

endmodule

// File: tb/tb_decode_hazard.sv
// -----------------------------------------------------------------------------
// tb_decode_hazard
//
// Self-checking bench for decode_hazard. A behavioural model built from an
// opcode property table predicts ID/EX contents and hazard outputs; one
// compare process checks them on every falling edge. Directed scenarios pin
// the model with literal values, then randomized traffic follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decode_hazard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr_IFID;
    logic [15:0] PC2_IFID;
    logic        halt_IFID;
    logic        takeBranch_EXMEM;
    logic        freeze;
    logic        wrEn_WB;
    logic [2:0]  wrReg_WB;
    logic [15:0] wrData_WB;
    logic        stallCtrl;
    logic        startStall;
    logic [15:0] rsData_IDEX;
    logic [15:0] rtData_IDEX;
    logic [15:0] imm_IDEX;
    logic [15:0] PC2_IDEX;
    logic [15:0] instr_IDEX;
    logic [2:0]  wrReg_IDEX;
    logic        regWrite_IDEX;
    logic        memRead_IDEX;
    logic        memWrite_IDEX;
    logic        halt_IDEX;
    logic        err;

    decode_hazard dut (
        .clk              (clk),
        .rst              (rst),
        .instr_IFID       (instr_IFID),
        .PC2_IFID         (PC2_IFID),
        .halt_IFID        (halt_IFID),
        .takeBranch_EXMEM (takeBranch_EXMEM),
        .freeze           (freeze),
        .wrEn_WB          (wrEn_WB),
        .wrReg_WB         (wrReg_WB),
        .wrData_WB        (wrData_WB),
        .stallCtrl        (stallCtrl),
        .startStall       (startStall),
        .rsData_IDEX      (rsData_IDEX),
        .rtData_IDEX      (rtData_IDEX),
        .imm_IDEX         (imm_IDEX),
        .PC2_IDEX         (PC2_IDEX),
        .instr_IDEX       (instr_IDEX),
        .wrReg_IDEX       (wrReg_IDEX),
        .regWrite_IDEX    (regWrite_IDEX),
        .memRead_IDEX     (memRead_IDEX),
        .memWrite_IDEX    (memWrite_IDEX),
        .halt_IDEX        (halt_IDEX),
        .err              (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic known;
        logic rd_rs;
        logic rd_rt;
        logic mem_r;
        logic mem_w;
        logic has_imm;
        logic dst_rd;   // destination in bits [4:2]
        logic dst_rt;   // destination in bits [7:5]
        logic is_halt;
    } prof_t;

    function automatic prof_t profile(input logic [4:0] op);
        prof_t p;
        p = '0;
        case (op)
            5'b11011: begin p.known = 1; p.rd_rs = 1; p.rd_rt = 1; p.dst_rd = 1; end
            5'b01000: begin p.known = 1; p.rd_rs = 1; p.has_imm = 1; p.dst_rt = 1; end
            5'b10001: begin p.known = 1; p.rd_rs = 1; p.has_imm = 1; p.dst_rt = 1; p.mem_r = 1; end
            5'b10000: begin p.known = 1; p.rd_rs = 1; p.rd_rt = 1; p.has_imm = 1; p.mem_w = 1; end
            5'b00001: p.known = 1;
            5'b00000: begin p.known = 1; p.is_halt = 1; end
            default:  p = '0;
        endcase
        return p;
    endfunction

    logic [15:0] m_rf [8];
    logic [15:0] m_rs, m_rt, m_imm, m_pc2, m_instr;
    logic [2:0]  m_wr;
    logic        m_rw, m_mr, m_mw, m_halt, m_prev;

    function automatic logic [15:0] m_read(input logic [2:0] idx);
`ifdef RF_BYPASS_EN
        if (wrEn_WB && wrReg_WB == idx) return wrData_WB;
`endif
        return m_rf[idx];
    endfunction

    function automatic logic exp_stall();
        prof_t p;
        p = profile(instr_IFID[15:11]);
        if (takeBranch_EXMEM || !m_mr) return 1'b0;
        return (p.rd_rs && m_wr == instr_IFID[10:8]) || (p.rd_rt && m_wr == instr_IFID[7:5]);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        prof_t p;
        logic  st;
        int    v;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_rf[i] = '0;
            m_rs = 0; m_rt = 0; m_imm = 0; m_pc2 = 0; m_instr = 16'h0800;
            m_wr = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_halt = 0; m_prev = 0;
        end else if (freeze) begin
            p  = profile(instr_IFID[15:11]);
            st = exp_stall();
            if (takeBranch_EXMEM || st || !p.known) begin
                m_rs = 0; m_rt = 0; m_imm = 0; m_pc2 = 0; m_instr = 16'h0800;
                m_wr = 0; m_rw = 0; m_mr = 0; m_mw = 0;
            end else begin
                v = int'(instr_IFID[4:0]);
                if (v > 15) v = v - 32;
                m_instr = instr_IFID;
                m_pc2   = PC2_IFID;
                m_rs    = p.rd_rs ? m_read(instr_IFID[10:8]) : 16'h0;
                m_rt    = p.rd_rt ? m_read(instr_IFID[7:5]) : 16'h0;
                m_imm   = p.has_imm ? v[15:0] : 16'h0;
                m_wr    = p.dst_rd ? instr_IFID[4:2] : (p.dst_rt ? instr_IFID[7:5] : 3'd0);
                m_rw    = p.dst_rd | p.dst_rt;
                m_mr    = p.mem_r;
                m_mw    = p.mem_w;
            end
            m_halt = (halt_IFID || p.is_halt) && !takeBranch_EXMEM && !st;
            m_prev = st;
            if (wrEn_WB) m_rf[wrReg_WB] = wrData_WB;
        end
    end

    // One compare process against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_stallCtrl",  stallCtrl,     exp_stall());
            check("cmp_startStall", startStall,    exp_stall() && !m_prev);
            check("cmp_err",        err,           !profile(instr_IFID[15:11]).known);
            check("cmp_rsData",     rsData_IDEX,   m_rs);
            check("cmp_rtData",     rtData_IDEX,   m_rt);
            check("cmp_imm",        imm_IDEX,      m_imm);
            check("cmp_PC2",        PC2_IDEX,      m_pc2);
            check("cmp_instr",      instr_IDEX,    m_instr);
            check("cmp_wrReg",      wrReg_IDEX,    m_wr);
            check("cmp_regWrite",   regWrite_IDEX, m_rw);
            check("cmp_memRead",    memRead_IDEX,  m_mr);
            check("cmp_memWrite",   memWrite_IDEX, m_mw);
            check("cmp_halt",       halt_IDEX,     m_halt);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    task automatic idle();
        instr_IFID       = 16'h0800;
        PC2_IFID         = 16'h0000;
        halt_IFID        = 1'b0;
        takeBranch_EXMEM = 1'b0;
        freeze           = 1'b1;
        wrEn_WB          = 1'b0;
        wrReg_WB         = 3'd0;
        wrData_WB        = 16'h0000;
    endtask

    task automatic edge_after();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] r5_seen;
    logic [4:0]  op;
    logic [15:0] rnd;

    initial begin
        idle();
        #1 rst = 1'b1;
        edge_after();
        edge_after();
        rst = 1'b0;
        cmp_en = 1'b1;

        // Reset values
        check("rst_instr", instr_IDEX, 16'h0800);
        check("rst_rs",    rsData_IDEX, 16'h0000);
        check("rst_stall", stallCtrl, 1'b0);
        check("rst_start", startStall, 1'b0);

        // Write r3 then decode an R-ALU reading it
        wrEn_WB = 1'b1; wrReg_WB = 3'd3; wrData_WB = 16'h1234;
        edge_after();
        wrEn_WB = 1'b0; instr_IFID = 16'hDB04; PC2_IFID = 16'h0022;  // RALU rs=3 rt=0 rd=1
        edge_after();
        check("wb_rs",     rsData_IDEX, 16'h1234);
        check("wb_instr",  instr_IDEX, 16'hDB04);
        check("wb_wrReg",  wrReg_IDEX, 3'd1);
        check("wb_pc2",    PC2_IDEX, 16'h0022);

        // Load-use: LD r2 then R-ALU reading rt=r2
        instr_IFID = 16'h8841;                                       // LD r2, 1(r0)
        edge_after();
        check("ld_memRead", memRead_IDEX, 1'b1);
        check("ld_imm",     imm_IDEX, 16'h0001);
        instr_IFID = 16'hD94C;                                       // RALU rs=1 rt=2 rd=3
        @(negedge clk);
        check("lu_stall",  stallCtrl, 1'b1);
        check("lu_start",  startStall, 1'b1);
        edge_after();
        check("lu_bubble", instr_IDEX, 16'h0800);
        @(negedge clk);
        check("lu_stall_end", stallCtrl, 1'b0);
        check("lu_start_end", startStall, 1'b0);
        edge_after();
        check("lu_resume", instr_IDEX, 16'hD94C);

        // Flush coinciding with load-use
        instr_IFID = 16'h8841;
        edge_after();
        instr_IFID = 16'hD94C; takeBranch_EXMEM = 1'b1;
        @(negedge clk);
        check("fl_stall", stallCtrl, 1'b0);
        edge_after();
        check("fl_instr",   instr_IDEX, 16'h0800);
        check("fl_memRead", memRead_IDEX, 1'b0);
        takeBranch_EXMEM = 1'b0;

        // Write-back to r5 while IF/ID reads r5
        instr_IFID = 16'h0800;
        wrEn_WB = 1'b1; wrReg_WB = 3'd5; wrData_WB = 16'h1111;
        edge_after();
        wrData_WB = 16'hBEEF; instr_IFID = 16'h4520;                 // ADDI r1, r5, 0
        edge_after();
        wrEn_WB = 1'b0;
`ifdef RF_BYPASS_EN
        r5_seen = 16'hBEEF;
`else
        r5_seen = 16'h1111;
`endif
        check("byp_rs", rsData_IDEX, r5_seen);

        // Freeze for three cycles with a new instruction and a write attempt
        freeze = 1'b0; instr_IFID = 16'hDB04;
        wrEn_WB = 1'b1; wrReg_WB = 3'd3; wrData_WB = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            edge_after();
            check("frz_instr", instr_IDEX, 16'h4520);
            check("frz_rs",    rsData_IDEX, r5_seen);
        end
        freeze = 1'b1; wrEn_WB = 1'b0;
        edge_after();
        check("unfrz_instr", instr_IDEX, 16'hDB04);
        check("unfrz_rs",    rsData_IDEX, 16'h1234);

        // Reset arriving mid-stall drops stallCtrl at once
        instr_IFID = 16'h8841;
        edge_after();
        instr_IFID = 16'hD94C;
        @(negedge clk);
        check("rs_stall_pre", stallCtrl, 1'b1);
        #2 rst = 1'b1;
        #1 check("rs_stall_drop", stallCtrl, 1'b0);
        #1 rst = 1'b0;
        edge_after();

        // Illegal opcode, then asynchronous reset mid-cycle
        instr_IFID = 16'hF800;
        @(negedge clk);
        check("ill_err", err, 1'b1);
        edge_after();
        check("ill_instr", instr_IDEX, 16'h0800);
        check("ill_pc2",   PC2_IDEX, 16'h0000);
        instr_IFID = 16'h4520;
        edge_after();
        check("pre_rst_instr", instr_IDEX, 16'h4520);
        instr_IFID = 16'hF800;
        @(negedge clk);
        check("ill_err2", err, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_instr",    instr_IDEX, 16'h0800);
        check("arst_rs",       rsData_IDEX, 16'h0000);
        check("arst_regWrite", regWrite_IDEX, 1'b0);
        check("arst_pc2",      PC2_IDEX, 16'h0000);
        #1 rst = 1'b0;
        edge_after();
        instr_IFID = 16'hDB04;
        edge_after();
        check("arst_rf_cleared", rsData_IDEX, 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            edge_after();
            rnd = 16'($urandom);
            case ($urandom_range(0, 9))
                0, 1:    op = 5'b10001;
                2, 3:    op = 5'b11011;
                4:       op = 5'b01000;
                5:       op = 5'b10000;
                6:       op = 5'b00001;
                7:       op = 5'b00000;
                default: op = 5'($urandom);
            endcase
            instr_IFID       = {op, rnd[10:0]};
            PC2_IFID         = 16'($urandom);
            halt_IFID        = (op == 5'b00000);
            takeBranch_EXMEM = ($urandom_range(0, 9) == 0);
            freeze           = ($urandom_range(0, 6) != 0);
            wrEn_WB          = $urandom_range(0, 1) == 1;
            wrReg_WB         = 3'($urandom);
            wrData_WB        = 16'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        edge_after();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
